// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, ALU encodings and control bundle for the 5-stage pipeline
package pipeline_pkg;

    localparam int PIPE_DW = 32;
    localparam int PIPE_AW = 5;
    localparam int PIPE_CW = 5;

    typedef enum logic [PIPE_CW-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_LUI  = 5'd11
    } alu_code_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic reg_dst;
        logic alu_src_a;
        logic alu_src_b;
    } ctrl_t;

    // Bubble controls: nothing written, no memory access.
    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection and stall request
module hazard_detect #(
    parameter int AW = 5
) (
    input  logic          mem_read_ex_i,
    input  logic          valid_ex_i,
    input  logic [AW-1:0] rt_addr_ex_i,
    input  logic [AW-1:0] rs_addr_id_i,
    input  logic [AW-1:0] rt_addr_id_i,
    input  logic          flush_id_i,
    input  logic          hold_ext_i,
    output logic          lu_o,
    output logic          stall_o
);

    // $0 is never a real producer, so a load into it cannot create a hazard.
    assign lu_o = mem_read_ex_i & valid_ex_i & (rt_addr_ex_i != '0) &
                  ((rt_addr_ex_i == rs_addr_id_i) | (rt_addr_ex_i == rt_addr_id_i));

    assign stall_o = lu_o & ~flush_id_i & ~hold_ext_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble insertion; ID_EX_PERF_EN adds StallCnt/FlushCnt
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DW = PIPE_DW,
    parameter int AW = PIPE_AW,
    parameter int CW = PIPE_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Flush_id,
    input  logic          Hold_ext,
    input  logic          RegWrite_id,
    input  logic          MemToReg_id,
    input  logic          MemRead_id,
    input  logic          MemWrite_id,
    input  logic          RegDst_id,
    input  logic          ALUSrcA_id,
    input  logic          ALUSrcB_id,
    input  logic [CW-1:0] ALUCode_id,
    input  logic [DW-1:0] Imm_id,
    input  logic [DW-1:0] Sa_id,
    input  logic [DW-1:0] RsData_id,
    input  logic [DW-1:0] RtData_id,
    input  logic [DW-1:0] PC_id,
    input  logic [AW-1:0] RsAddr_id,
    input  logic [AW-1:0] RtAddr_id,
    input  logic [AW-1:0] RdAddr_id,
    output logic          RegWrite_ex,
    output logic          MemToReg_ex,
    output logic          MemRead_ex,
    output logic          MemWrite_ex,
    output logic          RegDst_ex,
    output logic          ALUSrcA_ex,
    output logic          ALUSrcB_ex,
    output logic [CW-1:0] ALUCode_ex,
    output logic [DW-1:0] Imm_ex,
    output logic [DW-1:0] Sa_ex,
    output logic [DW-1:0] RsData_ex,
    output logic [DW-1:0] RtData_ex,
    output logic [DW-1:0] PC_ex,
    output logic [AW-1:0] RsAddr_ex,
    output logic [AW-1:0] RtAddr_ex,
    output logic [AW-1:0] RdAddr_ex,
    output logic          Valid_ex,
    output logic          Stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [31:0]   FlushCnt
`endif
);

    localparam int DATA_W = CW + 5*DW + 3*AW;

    ctrl_t              ctrl_id, ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  data_id, data_q, data_d;
    logic               valid_q, valid_d;
    logic               lu;

    assign ctrl_id = '{reg_write:  RegWrite_id,
                       mem_to_reg: MemToReg_id,
                       mem_read:   MemRead_id,
                       mem_write:  MemWrite_id,
                       reg_dst:    RegDst_id,
                       alu_src_a:  ALUSrcA_id,
                       alu_src_b:  ALUSrcB_id};

    assign data_id = {ALUCode_id, Imm_id, Sa_id, RsData_id, RtData_id, PC_id,
                      RsAddr_id, RtAddr_id, RdAddr_id};

    assign {ALUCode_ex, Imm_ex, Sa_ex, RsData_ex, RtData_ex, PC_ex,
            RsAddr_ex, RtAddr_ex, RdAddr_ex} = data_q;

    assign RegWrite_ex = ctrl_q.reg_write;
    assign MemToReg_ex = ctrl_q.mem_to_reg;
    assign MemRead_ex  = ctrl_q.mem_read;
    assign MemWrite_ex = ctrl_q.mem_write;
    assign RegDst_ex   = ctrl_q.reg_dst;
    assign ALUSrcA_ex  = ctrl_q.alu_src_a;
    assign ALUSrcB_ex  = ctrl_q.alu_src_b;
    assign Valid_ex    = valid_q;

    hazard_detect #(.AW(AW)) u_hazard_detect (
        .mem_read_ex_i (ctrl_q.mem_read),
        .valid_ex_i    (valid_q),
        .rt_addr_ex_i  (RtAddr_ex),
        .rs_addr_id_i  (RsAddr_id),
        .rt_addr_id_i  (RtAddr_id),
        .flush_id_i    (Flush_id),
        .hold_ext_i    (Hold_ext),
        .lu_o          (lu),
        .stall_o       (Stall)
    );

    // Flush and load-use both produce a fully cleared bubble; Hold_ext freezes everything.
    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (!Hold_ext) begin
            if (Flush_id || lu) begin
                ctrl_d  = NOP_CTRL;
                data_d  = '0;
                valid_d = 1'b0;
            end else begin
                ctrl_d  = ctrl_id;
                data_d  = data_id;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= NOP_CTRL;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Stall already excludes flush and hold, so it marks exactly the load-use bubbles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (Flush_id && !Hold_ext) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
